// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register built as a 2-entry skid buffer (head M drives EX, skid S absorbs
// one extra op) so decode sees a registered in_ready while the pipe still moves 1 op/cycle.

package cpu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;
endpackage

module id_ex_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  alu_op_t               in_alu_op,
    input  logic [DATA_W-1:0]     in_src_a,
    input  logic [DATA_W-1:0]     in_src_b,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_we,
    output logic                  out_valid,
    input  logic                  out_ready,
    output alu_op_t               out_alu_op,
    output logic [DATA_W-1:0]     out_src_a,
    output logic [DATA_W-1:0]     out_src_b,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_we,
    output logic [1:0]            occupancy
);

    typedef struct packed {
        alu_op_t                alu_op;
        logic [DATA_W-1:0]      src_a;
        logic [DATA_W-1:0]      src_b;
        logic [REG_ADDR_W-1:0]  rd;
        logic                   reg_we;
    } entry_t;

    // State encoding doubles as the entry count, so occupancy is just the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t m_q, m_d;
    entry_t s_q, s_d;
    logic   in_ready_q, in_ready_d;
    logic   in_fire, out_fire;
    entry_t in_entry;

    assign in_entry  = '{alu_op: in_alu_op, src_a: in_src_a, src_b: in_src_b,
                         rd: in_rd, reg_we: in_reg_we};
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        m_d     = in_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        m_d = in_entry;
                    end else if (in_fire) begin
                        s_d     = in_entry;
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        m_d     = s_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        // Skid full next cycle is the only reason to stall decode.
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            m_q        <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            s_q        <= s_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign out_alu_op = m_q.alu_op;
    assign out_src_a  = m_q.src_a;
    assign out_src_b  = m_q.src_b;
    assign out_rd     = m_q.rd;
    assign out_reg_we = m_q.reg_we;
    assign occupancy  = state_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: directed scenarios then random traffic, checked against a FIFO-queue
// model of capacity two whose accept/consume rules follow the valid/ready contract.

module tb_id_ex_pipe;
    import cpu_pkg::*;

    typedef struct packed {
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    alu_op_t     in_alu_op = ALU_ADD;
    logic [31:0] in_src_a = '0;
    logic [31:0] in_src_b = '0;
    logic [4:0]  in_rd = '0;
    logic        in_reg_we = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    alu_op_t     out_alu_op;
    logic [31:0] out_src_a;
    logic [31:0] out_src_b;
    logic [4:0]  out_rd;
    logic        out_reg_we;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;
    op_t mq[$];

    id_ex_pipe #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_src_a(in_src_a), .in_src_b(in_src_b),
        .in_rd(in_rd), .in_reg_we(in_reg_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_src_a(out_src_a), .out_src_b(out_src_b),
        .out_rd(out_rd), .out_reg_we(out_reg_we), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic op_t dut_head();
        return '{op: out_alu_op, a: out_src_a, b: out_src_b, rd: out_rd, we: out_reg_we};
    endfunction

    function automatic op_t mk(input alu_op_t o, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
        return '{op: o, a: a, b: b, rd: rd, we: 1'b1};
    endfunction

    function automatic op_t rand_op();
        return '{op: alu_op_t'($urandom_range(0, 9)), a: $urandom, b: $urandom,
                 rd: 5'($urandom_range(0, 31)), we: 1'($urandom_range(0, 1))};
    endfunction

    task automatic drive(input bit v, input op_t p);
        in_valid  = v;
        in_alu_op = p.op;
        in_src_a  = p.a;
        in_src_b  = p.b;
        in_rd     = p.rd;
        in_reg_we = p.we;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out_valid"}, 80'(out_valid), 80'(mq.size() != 0));
        chk({tag, ".occupancy"}, 80'(occupancy), 80'(mq.size()));
        chk({tag, ".in_ready"}, 80'(in_ready), 80'(mq.size() < 2));
        if (mq.size() != 0) chk({tag, ".head"}, 80'(dut_head()), 80'(mq[0]));
    endtask

    // One clock: decide fires from the model before the edge, apply them after it, compare.
    task automatic cycle(input string tag);
        bit  inf, outf;
        op_t cur;
        inf  = in_valid && (mq.size() < 2);
        outf = out_ready && (mq.size() != 0);
        cur  = '{op: in_alu_op, a: in_src_a, b: in_src_b, rd: in_rd, we: in_reg_we};
        @(posedge clk);
        #1;
        if (flush) begin
            mq.delete();
        end else begin
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back(cur);
        end
        check_model(tag);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".out_valid"}, 80'(out_valid), 80'(0));
        chk({tag, ".in_ready"}, 80'(in_ready), 80'(1));
        chk({tag, ".occupancy"}, 80'(occupancy), 80'(0));
    endtask

    initial begin
        op_t a, b, c, hold;
        a = mk(ALU_ADD, 32'h5, 32'h3, 5'd1);
        b = mk(ALU_SUB, 32'h9, 32'h4, 5'd2);
        c = mk(ALU_XOR, 32'hF0, 32'h0F, 5'd3);

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        chk("reset.data", 80'(dut_head()), 80'(0));
        #2 rst_n = 1'b1;

        // 1: back-to-back with EX always ready
        out_ready = 1'b1;
        drive(1, a); cycle("t1.a");
        chk("t1.a_src_a", 80'(out_src_a), 80'(32'h5));
        drive(1, b); cycle("t1.b");
        drive(1, c); cycle("t1.c");
        chk("t1.c_op", 80'(out_alu_op), 80'(ALU_XOR));
        drive(0, c); cycle("t1.drain");

        // 2: EX stalled, fill to FULL, then release
        out_ready = 1'b0;
        drive(1, a); cycle("t2.a");
        drive(1, b); cycle("t2.b");
        chk("t2.full_ready", 80'(in_ready), 80'(0));
        drive(1, c); cycle("t2.c_held");
        cycle("t2.c_held2");
        out_ready = 1'b1;
        repeat (4) cycle("t2.release");
        drive(0, c); cycle("t2.drain");

        // 3: ONE state, simultaneous accept and consume
        out_ready = 1'b0;
        drive(1, a); cycle("t3.a");
        out_ready = 1'b1;
        drive(1, b); cycle("t3.swap");
        chk("t3.occ", 80'(occupancy), 80'(1));
        chk("t3.src_a", 80'(out_src_a), 80'(32'h9));
        drive(0, b); cycle("t3.drain");

        // 4: flush while FULL with a new op offered
        out_ready = 1'b0;
        drive(1, a); cycle("t4.a");
        drive(1, b); cycle("t4.b");
        drive(1, c); flush = 1'b1; cycle("t4.flush");
        flush = 1'b0; drive(0, c);
        check_reset_state("t4.after_flush");
        out_ready = 1'b1;
        repeat (2) cycle("t4.idle");

        // 5: head holds while EX stalls and inputs toggle
        out_ready = 1'b0;
        drive(1, rand_op()); cycle("t5.load");
        hold = dut_head();
        for (int i = 0; i < 5; i++) begin
            drive(1'(i & 1), rand_op());
            cycle("t5.stall");
            chk("t5.stable", 80'(dut_head()), 80'(hold));
        end

        // 6: async reset between edges with a FULL buffer
        drive(1, a); cycle("t6.fill");
        drive(0, a);
        #3 rst_n = 1'b0;
        #1;
        check_reset_state("t6.async");
        mq.delete();
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1, c); cycle("t6.restart");
        chk("t6.restart_src_b", 80'(out_src_b), 80'(32'h0F));
        drive(0, c); cycle("t6.drain");

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rand_op());
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 15) == 0);
            cycle("rand");
        end
        flush = 1'b0;
        drive(0, a);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
